// File: rtl/mips32_pipe_core.sv
// rtl/mips32_pipe_core.sv - five-stage pipelined MIPS-subset core with unified memory
//
// Purpose: IF/ID/EX/MEM/WB pipeline running a preloaded program from pc 0
//          until a HLT retires. One word-addressed memory holds both code
//          and data. Forwarding from EX/MEM and MEM/WB into EX, a regfile
//          write-through bypass into ID, a one-cycle load-use stall, and
//          branches resolved in EX with a two-instruction squash.
// Ports:
//   clk - system clock, all state changes on the rising edge
//   rst - synchronous active-high reset (pipeline and pc only)
// Hierarchically visible state: mem, regfile, pc, halted, taken_branch.

module mips32_pipe_core #(
    parameter int MEM_WORDS = 1024,
    parameter int XLEN      = 32
) (
    input logic clk,
    input logic rst
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [XLEN-1:0] ONE = 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Architectural state
    logic [XLEN-1:0] mem [0:MEM_WORDS-1];
    logic [XLEN-1:0] regfile [0:31];
    logic [XLEN-1:0] pc;
    logic            halted;
    logic            taken_branch;

    // Set once an unsquashed HLT is decoded; keeps fetch stopped
    logic            hlt_pending;

    // IF/ID
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_ir;
    logic [XLEN-1:0] if_id_npc;

    // ID/EX
    logic            id_ex_valid;
    logic [5:0]      id_ex_op;
    logic [4:0]      id_ex_rs;
    logic [4:0]      id_ex_rt;
    logic [4:0]      id_ex_dest;
    logic            id_ex_wr;
    logic [XLEN-1:0] id_ex_a;
    logic [XLEN-1:0] id_ex_b;
    logic [XLEN-1:0] id_ex_imm;
    logic [XLEN-1:0] id_ex_npc;

    // EX/MEM
    logic            ex_mem_valid;
    logic            ex_mem_wr;
    logic [4:0]      ex_mem_dest;
    logic [XLEN-1:0] ex_mem_alu;
    logic [XLEN-1:0] ex_mem_sdata;
    logic            ex_mem_is_load;
    logic            ex_mem_is_store;
    logic            ex_mem_is_hlt;

    // MEM/WB
    logic            mem_wb_valid;
    logic            mem_wb_wr;
    logic [4:0]      mem_wb_dest;
    logic [XLEN-1:0] mem_wb_result;
    logic            mem_wb_is_hlt;

    // ---------------- ID stage decode ----------------
    logic [5:0]      id_op;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_imm;
    logic            id_is_r;
    logic            id_is_iwr;
    logic            id_uses_rs;
    logic            id_uses_rt;
    logic            id_is_hlt;
    logic [XLEN-1:0] id_a;
    logic [XLEN-1:0] id_b;
    logic            wb_we;

    assign id_op  = if_id_ir[31:26];
    assign id_rs  = if_id_ir[25:21];
    assign id_rt  = if_id_ir[20:16];
    assign id_rd  = if_id_ir[15:11];
    assign id_imm = {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};

    // R-type opcodes are the contiguous range ADD..MUL
    assign id_is_r    = (id_op <= OP_MUL);
    assign id_is_iwr  = (id_op == OP_LW) || (id_op == OP_ADDI) ||
                        (id_op == OP_SUBI) || (id_op == OP_SLTI);
    assign id_uses_rs = id_is_r || id_is_iwr || (id_op == OP_SW) ||
                        (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
    assign id_uses_rt = id_is_r || (id_op == OP_SW);
    assign id_is_hlt  = if_id_valid && (id_op == OP_HLT);

    assign wb_we = mem_wb_valid && mem_wb_wr && (mem_wb_dest != 5'd0);

    // Register read with write-through of the value retiring this cycle
    always_comb begin
        id_a = '0;
        id_b = '0;
        if (id_rs != 5'd0) begin
            if (wb_we && (mem_wb_dest == id_rs)) id_a = mem_wb_result;
            else                                 id_a = regfile[id_rs];
        end
        if (id_rt != 5'd0) begin
            if (wb_we && (mem_wb_dest == id_rt)) id_b = mem_wb_result;
            else                                 id_b = regfile[id_rt];
        end
    end

    // ---------------- Hazard control ----------------
    logic load_use;
    logic flush;
    logic stop_fetch;

    // Load result only exists after MEM, so a dependent instruction directly
    // behind a LW waits one cycle in ID.
    assign load_use = id_ex_valid && (id_ex_op == OP_LW) && (id_ex_dest != 5'd0) &&
                      if_id_valid &&
                      ((id_uses_rs && (id_rs == id_ex_dest)) ||
                       (id_uses_rt && (id_rt == id_ex_dest)));

    assign flush      = taken_branch;
    // A HLT sitting in a taken-branch shadow must not stop fetch
    assign stop_fetch = hlt_pending || (id_is_hlt && !flush);

    // ---------------- EX stage ----------------
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] br_target;

    always_comb begin
        fwd_a = id_ex_a;
        if (ex_mem_valid && ex_mem_wr && !ex_mem_is_load &&
            (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rs))
            fwd_a = ex_mem_alu;
        else if (wb_we && (mem_wb_dest == id_ex_rs))
            fwd_a = mem_wb_result;

        fwd_b = id_ex_b;
        if (ex_mem_valid && ex_mem_wr && !ex_mem_is_load &&
            (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rt))
            fwd_b = ex_mem_alu;
        else if (wb_we && (mem_wb_dest == id_ex_rt))
            fwd_b = mem_wb_result;
    end

    always_comb begin
        alu = '0;
        case (id_ex_op)
            OP_ADD:  alu = fwd_a + fwd_b;
            OP_SUB:  alu = fwd_a - fwd_b;
            OP_AND:  alu = fwd_a & fwd_b;
            OP_OR:   alu = fwd_a | fwd_b;
            OP_SLT:  alu = ($signed(fwd_a) < $signed(fwd_b)) ? ONE : '0;
            OP_MUL:  alu = fwd_a * fwd_b;
            OP_LW,
            OP_SW,
            OP_ADDI: alu = fwd_a + id_ex_imm;
            OP_SUBI: alu = fwd_a - id_ex_imm;
            OP_SLTI: alu = ($signed(fwd_a) < $signed(id_ex_imm)) ? ONE : '0;
            default: alu = '0;
        endcase
    end

    assign taken_branch = id_ex_valid &&
                          (((id_ex_op == OP_BNEQZ) && (fwd_a != '0)) ||
                           ((id_ex_op == OP_BEQZ)  && (fwd_a == '0)));
    assign br_target = id_ex_npc + id_ex_imm;

    // ---------------- MEM stage read ----------------
    logic [XLEN-1:0] mem_rdata;
    assign mem_rdata = mem[ex_mem_alu[AW-1:0]];

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            halted       <= 1'b0;
            hlt_pending  <= 1'b0;
            if_id_valid  <= 1'b0;
            id_ex_valid  <= 1'b0;
            ex_mem_valid <= 1'b0;
            mem_wb_valid <= 1'b0;
        end else if (!halted) begin
            // IF
            if (flush)
                pc <= br_target;
            else if (!stop_fetch && !load_use)
                pc <= pc + ONE;

            if (flush || stop_fetch) begin
                if_id_valid <= 1'b0;
            end else if (!load_use) begin
                if_id_valid <= 1'b1;
                if_id_ir    <= mem[pc[AW-1:0]];
                if_id_npc   <= pc + ONE;
            end

            if (id_is_hlt && !flush)
                hlt_pending <= 1'b1;

            // ID -> EX
            id_ex_valid <= if_id_valid && !flush && !load_use;
            id_ex_op    <= id_op;
            id_ex_rs    <= id_rs;
            id_ex_rt    <= id_rt;
            id_ex_dest  <= id_is_r ? id_rd : id_rt;
            id_ex_wr    <= id_is_r || id_is_iwr;
            id_ex_a     <= id_a;
            id_ex_b     <= id_b;
            id_ex_imm   <= id_imm;
            id_ex_npc   <= if_id_npc;

            // EX -> MEM
            ex_mem_valid    <= id_ex_valid;
            ex_mem_wr       <= id_ex_wr;
            ex_mem_dest     <= id_ex_dest;
            ex_mem_alu      <= alu;
            ex_mem_sdata    <= fwd_b;
            ex_mem_is_load  <= (id_ex_op == OP_LW);
            ex_mem_is_store <= (id_ex_op == OP_SW);
            ex_mem_is_hlt   <= (id_ex_op == OP_HLT);

            // MEM -> WB
            mem_wb_valid  <= ex_mem_valid;
            mem_wb_wr     <= ex_mem_wr;
            mem_wb_dest   <= ex_mem_dest;
            mem_wb_result <= ex_mem_is_load ? mem_rdata : ex_mem_alu;
            mem_wb_is_hlt <= ex_mem_is_hlt;

            // HLT in WB: everything older has already retired
            if (mem_wb_valid && mem_wb_is_hlt)
                halted <= 1'b1;
        end
    end

    // Store in MEM; reset discards the in-flight store
    always_ff @(posedge clk) begin
        if (!rst && !halted && ex_mem_valid && ex_mem_is_store)
            mem[ex_mem_alu[AW-1:0]] <= ex_mem_sdata;
    end

    // Register write in WB; r0 is never written
    always_ff @(posedge clk) begin
        if (!rst && !halted && wb_we)
            regfile[mem_wb_dest] <= mem_wb_result;
    end

endmodule

// File: tb/tb_mips32_pipe_core.sv
// tb/tb_mips32_pipe_core.sv - self-checking bench for mips32_pipe_core
module tb_mips32_pipe_core;

    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
    localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
    localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63, UNDEF = 6'd16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips32_pipe_core #(.MEM_WORDS(1024), .XLEN(32)) dut (.clk(clk), .rst(rst));

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] img_mem [0:1023];
    logic [31:0] img_reg [0:31];
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_reg [0:31];
    bit          exp_taken [0:4095];
    int          exp_halt_edge;
    int          exp_taken_cnt;
    logic [31:0] exp_pc;
    int          wp;

    int edge_cnt;
    bit chk_en = 1'b0;
    int taken_seen;
    int halt_edge_seen;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] rt_(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] it_(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic put(input logic [31:0] ins);
        img_mem[wp] = ins;
        wp++;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) img_reg[i] = 32'd0;
        wp = 0;
    endtask

    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // ISA-level interpreter plus timing rules: each instruction takes one
    // fetch slot, a dependent right after LW adds one, a taken branch adds two;
    // a branch's EX cycle follows its fetch, HLT raises halted 4 edges after fetch.
    task automatic model_run();
        logic [31:0] pcm, ir, a, b, imm, res, addr;
        logic [5:0] op;
        int rs, rt, rd, dest, t, prev_ld, stall, ex_e;
        bit wr, taken, urs, urt;
        for (int i = 0; i < 4096; i++) exp_taken[i] = 1'b0;
        exp_halt_edge = 1 << 30;
        exp_taken_cnt = 0;
        exp_pc = 32'hFFFF_FFFF;
        pcm = 0; t = 1; prev_ld = 0;
        for (int step = 0; step < 4000; step++) begin
            addr = pcm & 32'h3FF;
            ir = m_mem[addr];
            op = ir[31:26]; rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a = (rs == 0) ? 32'd0 : m_reg[rs];
            b = (rt == 0) ? 32'd0 : m_reg[rt];
            urs = (op <= MUL) || (op >= LW && op <= BEQZ);
            urt = (op <= MUL) || (op == SW);
            stall = (prev_ld != 0 && ((urs && rs == prev_ld) || (urt && rt == prev_ld))) ? 1 : 0;
            if (op == HLT) begin
                exp_halt_edge = t + 4;
                exp_pc = pcm + 1;
                break;
            end
            wr = 1'b0; taken = 1'b0; dest = rt; res = 32'd0;
            case (op)
                ADD:   begin res = a + b; wr = 1'b1; dest = rd; end
                SUB:   begin res = a - b; wr = 1'b1; dest = rd; end
                AND_:  begin res = a & b; wr = 1'b1; dest = rd; end
                OR_:   begin res = a | b; wr = 1'b1; dest = rd; end
                SLT:   begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; dest = rd; end
                MUL:   begin res = a * b; wr = 1'b1; dest = rd; end
                LW:    begin addr = (a + imm) & 32'h3FF; res = m_mem[addr]; wr = 1'b1; end
                SW:    begin addr = (a + imm) & 32'h3FF; m_mem[addr] = b; end
                ADDI:  begin res = a + imm; wr = 1'b1; end
                SUBI:  begin res = a - imm; wr = 1'b1; end
                SLTI:  begin res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; wr = 1'b1; end
                BNEQZ: taken = (a != 0);
                BEQZ:  taken = (a == 0);
                default: ;
            endcase
            if (wr && dest != 0) m_reg[dest] = res;
            ex_e = t + 1 + stall;
            if (taken) begin
                if (ex_e < 4096) exp_taken[ex_e] = 1'b1;
                exp_taken_cnt++;
                pcm = pcm + 1 + imm;
                t = ex_e + 2;
            end else begin
                pcm = pcm + 1;
                t = ex_e;
            end
            prev_ld = (op == LW) ? rt : 0;
        end
    endtask

    // Per-cycle compare against the model's timeline
    always @(negedge clk) begin
        if (chk_en) begin
            check("halted_cycle", {31'd0, dut.halted}, (edge_cnt >= exp_halt_edge) ? 32'd1 : 32'd0);
            check("taken_branch_cycle", {31'd0, dut.taken_branch},
                  (edge_cnt < 4096 && exp_taken[edge_cnt]) ? 32'd1 : 32'd0);
            if (dut.halted) check("pc_frozen", dut.pc, exp_pc);
            if (dut.taken_branch) taken_seen++;
            if (dut.halted && halt_edge_seen < 0) halt_edge_seen = edge_cnt;
        end
    end

    task automatic run_prog(input string name, input int rst_after);
        int bad;
        int cyc;
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_reset_pc"}, dut.pc, 32'd0);
        check({name, "_reset_halted"}, {31'd0, dut.halted}, 32'd0);
        check({name, "_reset_taken"}, {31'd0, dut.taken_branch}, 32'd0);
        for (int i = 0; i < 1024; i++) begin
            dut.mem[i] = img_mem[i];
            m_mem[i] = img_mem[i];
        end
        for (int i = 0; i < 32; i++) begin
            dut.regfile[i] = img_reg[i];
            m_reg[i] = img_reg[i];
        end
        model_run();
        taken_seen = 0;
        halt_edge_seen = -1;
        rst = 1'b0;
        chk_en = 1'b1;
        if (rst_after > 0) begin
            repeat (rst_after) @(negedge clk);
            chk_en = 1'b0;
            rst = 1'b1;
            repeat (2) @(negedge clk);
            taken_seen = 0;
            halt_edge_seen = -1;
            rst = 1'b0;
            chk_en = 1'b1;
        end
        cyc = 0;
        while (!dut.halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_halt_reached"}, {31'd0, dut.halted}, 32'd1);
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        for (int i = 1; i < 32; i++)
            check($sformatf("%s_r%0d", name, i), dut.regfile[i], m_reg[i]);
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (dut.mem[i] !== m_mem[i]) bad++;
        check({name, "_mem_words_differing"}, bad, 32'd0);
        check({name, "_taken_count"}, taken_seen, exp_taken_cnt);
    endtask

    initial begin
        // Arithmetic, back-to-back dependencies
        clear_img();
        put(it_(ADDI, 1, 0, 10));
        put(it_(ADDI, 2, 0, 20));
        put(rt_(ADD, 3, 1, 2));
        put(it_(HLT, 0, 0, 0));
        run_prog("arith", 0);
        check("arith_r3_lit", dut.regfile[3], 32'd30);
        check("arith_pc_lit", dut.pc, 32'd4);
        check("arith_halt_edge_lit", halt_edge_seen, 32'd8);

        // Logic, compare, r0 and undefined opcode
        clear_img();
        img_reg[10] = 32'h77;
        img_reg[11] = 32'h55;
        put(it_(ADDI, 1, 0, 12));
        put(it_(ADDI, 2, 0, 10));
        put(it_(ADDI, 5, 0, -2));
        put(rt_(AND_, 3, 1, 2));
        put(rt_(OR_, 4, 1, 2));
        put(rt_(SUB, 7, 1, 2));
        put(rt_(SLT, 9, 1, 2));
        put(it_(SLTI, 6, 5, 0));
        put(rt_(MUL, 8, 1, 2));
        put(it_(ADDI, 0, 0, 5));
        put(rt_(ADD, 10, 0, 0));
        put(it_(UNDEF, 11, 1, 3));
        put(rt_(SLT, 12, 5, 1));
        put(it_(HLT, 0, 0, 0));
        run_prog("logic", 0);
        check("logic_and_lit", dut.regfile[3], 32'd8);
        check("logic_or_lit", dut.regfile[4], 32'd14);
        check("logic_sub_lit", dut.regfile[7], 32'd2);
        check("logic_slt_lit", dut.regfile[9], 32'd0);
        check("logic_slti_lit", dut.regfile[6], 32'd1);
        check("logic_mul_lit", dut.regfile[8], 32'd120);
        check("logic_r0_lit", dut.regfile[10], 32'd0);
        check("logic_undef_lit", dut.regfile[11], 32'h55);
        check("logic_slt_neg_lit", dut.regfile[12], 32'd1);

        // Memory with load-use stall and store-then-load
        clear_img();
        img_mem[120] = 32'd85;
        put(it_(ADDI, 1, 0, 120));
        put(it_(LW, 2, 1, 0));
        put(it_(ADDI, 2, 2, 45));
        put(it_(SW, 2, 1, 1));
        put(it_(LW, 3, 1, 1));
        put(it_(HLT, 0, 0, 0));
        run_prog("memory", 0);
        check("memory_m121_lit", dut.mem[121], 32'd130);
        check("memory_r3_lit", dut.regfile[3], 32'd130);
        check("memory_halt_edge_lit", halt_edge_seen, 32'd11);

        // Factorial loop; SW and HLT sit in the BNEQZ shadow
        clear_img();
        img_mem[200] = 32'd7;
        put(it_(ADDI, 10, 0, 200));
        put(it_(ADDI, 2, 0, 1));
        put(it_(LW, 3, 10, 0));
        put(rt_(MUL, 2, 2, 3));
        put(it_(SUBI, 3, 3, 1));
        put(it_(BNEQZ, 0, 3, -3));
        put(it_(SW, 2, 10, -2));
        put(it_(HLT, 0, 0, 0));
        run_prog("fact", 0);
        check("fact_m198_lit", dut.mem[198], 32'd5040);
        check("fact_taken_lit", taken_seen, 32'd6);

        // Squash of the two younger instructions after each taken branch
        clear_img();
        img_reg[20] = 32'd7;
        img_reg[21] = 32'd7;
        put(it_(ADDI, 1, 0, 0));
        put(it_(BEQZ, 0, 1, 2));
        put(it_(ADDI, 20, 0, 99));
        put(it_(ADDI, 20, 0, 99));
        put(it_(ADDI, 2, 0, 3));
        put(it_(BNEQZ, 0, 2, 2));
        put(it_(ADDI, 21, 0, 99));
        put(it_(ADDI, 21, 0, 99));
        put(it_(BEQZ, 0, 2, 5));
        put(it_(BEQZ, 0, 0, 2));
        put(it_(HLT, 0, 0, 0));
        put(it_(ADDI, 20, 0, 99));
        put(it_(HLT, 0, 0, 0));
        run_prog("squash", 0);
        check("squash_r20_lit", dut.regfile[20], 32'd7);
        check("squash_r21_lit", dut.regfile[21], 32'd7);
        check("squash_taken_lit", taken_seen, 32'd3);
        check("squash_pc_lit", dut.pc, 32'd13);

        // Set-bit count of 29, once straight and once with a mid-run reset
        for (int pass = 0; pass < 2; pass++) begin
            clear_img();
            put(it_(ADDI, 1, 0, 29));
            put(rt_(ADD, 5, 1, 0));
            put(it_(ADDI, 10, 0, 1));
            put(it_(ADDI, 2, 0, 0));
            put(it_(ADDI, 6, 0, 8));
            put(rt_(AND_, 4, 5, 10));
            put(it_(BEQZ, 0, 4, 1));
            put(it_(ADDI, 2, 2, 1));
            put(it_(ADDI, 7, 0, 0));
            put(it_(SLTI, 8, 5, 2));
            put(it_(BNEQZ, 0, 8, 3));
            put(it_(SUBI, 5, 5, 2));
            put(it_(ADDI, 7, 7, 1));
            put(it_(BEQZ, 0, 0, -5));
            put(rt_(ADD, 5, 7, 0));
            put(it_(SUBI, 6, 6, 1));
            put(it_(BNEQZ, 0, 6, -12));
            put(it_(HLT, 0, 0, 0));
            run_prog(pass == 0 ? "bits" : "bits_rst", pass == 0 ? 0 : 60);
            check(pass == 0 ? "bits_r2_lit" : "bits_rst_r2_lit", dut.regfile[2], 32'd4);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
